// File: rtl/phy_reset_sequencer.sv
// Power-up reset sequencer: holds all PHYs in reset, releases them one at a time,
// then waits for every ready flag, retrying on timeout and latching a fault when out of retries.
module phy_reset_sequencer #(
  parameter int unsigned NUM_PHY        = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned HOLD_CYCLES    = 1000,
  parameter int unsigned STAGGER_CYCLES = 200,
  parameter int unsigned READY_TIMEOUT  = 5000,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               pwr_good,
  input  logic               rst_req,
  input  logic [NUM_PHY-1:0] phy_ready,
  output logic [NUM_PHY-1:0] phy_rst_l,
  output logic               seq_done,
  output logic               seq_fault,
  output logic [2:0]         seq_state
);

  localparam int unsigned IDX_W = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST  = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(READY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_PHY - 1);
  localparam logic [3:0]           RETRY_LIM  = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    STAGGER  = 3'd2,
    WAIT_RDY = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           retry;

  logic [IDX_W-1:0]     nxt_idx_c;
  logic                 all_ready_c;
  logic                 active_c;

  assign nxt_idx_c   = idx + IDX_W'(1);
  assign all_ready_c = &phy_ready;
  assign active_c    = (state == HOLD) || (state == STAGGER) || (state == WAIT_RDY) ||
                       (state == RUN)  || (state == FAULT);
  assign seq_state   = state;

  // Sequencer: brown-out beats software restart beats the normal flow.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      phy_rst_l <= '0;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
    end else if (!pwr_good) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      phy_rst_l <= '0;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
    end else if (rst_req && active_c) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      phy_rst_l <= '0;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= HOLD;
          cnt   <= '0;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            idx       <= '0;
            phy_rst_l <= NUM_PHY'(1);
            state     <= (NUM_PHY == 1) ? WAIT_RDY : STAGGER;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        STAGGER: begin
          if (cnt == STAG_LAST) begin
            cnt       <= '0;
            idx       <= nxt_idx_c;
            phy_rst_l <= phy_rst_l | (NUM_PHY'(1) << nxt_idx_c);
            if (nxt_idx_c == LAST_IDX) state <= WAIT_RDY;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        WAIT_RDY: begin
          // Ready takes precedence over a coincident timeout.
          if (all_ready_c) begin
            state    <= RUN;
            cnt      <= '0;
            seq_done <= 1'b1;
          end else if (cnt == TO_LAST) begin
            cnt       <= '0;
            phy_rst_l <= '0;
            if (retry < RETRY_LIM) begin
              retry <= retry + 4'(1);
              state <= HOLD;
            end else begin
              seq_fault <= 1'b1;
              state     <= FAULT;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        RUN:   ;
        FAULT: ;
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          idx       <= '0;
          phy_rst_l <= '0;
          seq_done  <= 1'b0;
          seq_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_reset_sequencer.sv
// Bench for phy_reset_sequencer: elapsed-time reference model compared every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_phy_reset_sequencer;

  localparam int NP   = 2;
  localparam int HOLD = 4;
  localparam int STAG = 3;
  localparam int TO   = 6;
  localparam int RMAX = 1;
  localparam int TW   = HOLD + (NP - 1) * STAG;  // pass time at which waiting for ready begins

  logic          clk = 1'b0;
  logic          rst_l;
  logic          pwr_good;
  logic          rst_req;
  logic [NP-1:0] phy_ready;
  logic [NP-1:0] phy_rst_l;
  logic          seq_done;
  logic          seq_fault;
  logic [2:0]    seq_state;

  int n_pass  = 0;
  int n_total = 0;

  phy_reset_sequencer #(
    .NUM_PHY(NP), .CNT_WIDTH(16), .HOLD_CYCLES(HOLD),
    .STAGGER_CYCLES(STAG), .READY_TIMEOUT(TO), .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst_l(rst_l), .pwr_good(pwr_good), .rst_req(rst_req),
    .phy_ready(phy_ready), .phy_rst_l(phy_rst_l), .seq_done(seq_done),
    .seq_fault(seq_fault), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 sequencing, 2 run, 3 fault; t = edges since pass start.
  int m_mode  = 0;
  int m_t     = 0;
  int m_retry = 0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_mode = 0; m_t = 0; m_retry = 0;
    end else if (!pwr_good) begin
      m_mode = 0; m_retry = 0;
    end else if (rst_req && m_mode != 0) begin
      m_mode = 1; m_t = 0; m_retry = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_t = 0;
    end else if (m_mode == 1) begin
      if (m_t >= TW && (&phy_ready)) m_mode = 2;
      else if (m_t >= TW && m_t - TW == TO - 1) begin
        if (m_retry < RMAX) begin m_retry++; m_t = 0; end
        else m_mode = 3;
      end else m_t++;
    end
  end

  function automatic int exp_state();
    case (m_mode)
      0: return 0;
      2: return 4;
      3: return 5;
      default: return (m_t < HOLD) ? 1 : (m_t < TW) ? 2 : 3;
    endcase
  endfunction

  function automatic int exp_rst();
    int rel;
    if (m_mode == 2) return (1 << NP) - 1;
    if (m_mode != 1 || m_t < HOLD) return 0;
    rel = (m_t - HOLD) / STAG + 1;
    if (rel > NP) rel = NP;
    return (1 << rel) - 1;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("state", int'(seq_state), exp_state());
    check("phy_rst_l", int'(phy_rst_l), exp_rst());
    check("seq_done", int'(seq_done), (m_mode == 2) ? 1 : 0);
    check("seq_fault", int'(seq_fault), (m_mode == 3) ? 1 : 0);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_l = 1'b0; pwr_good = 1'b0; rst_req = 1'b0; phy_ready = '0;
    #2;
    check("rst_phy", int'(phy_rst_l), 0);
    check("rst_state", int'(seq_state), 0);
    check("rst_done", int'(seq_done), 0);
    check("rst_fault", int'(seq_fault), 0);
    #21 rst_l = 1'b1;

    // Nominal sequence
    @(negedge clk); pwr_good = 1'b1;
    edges(1); check("nom_hold@0", int'(seq_state), 1);
    edges(4); check("nom_rel0@4", int'(phy_rst_l), 1); check("nom_stag@4", int'(seq_state), 2);
    edges(3); check("nom_rel1@7", int'(phy_rst_l), 3); check("nom_wait@7", int'(seq_state), 3);
    edges(1); phy_ready = 2'b11;
    edges(1); check("nom_run@9", int'(seq_state), 4); check("nom_done@9", int'(seq_done), 1);

    // rst_req in RUN
    rst_req = 1'b1; edges(1); rst_req = 1'b0;
    check("req_state", int'(seq_state), 1); check("req_phy", int'(phy_rst_l), 0);
    check("req_done", int'(seq_done), 0);
    edges(3); check("req_phy_still", int'(phy_rst_l), 0);
    edges(1); check("req_rel0", int'(phy_rst_l), 1);

    // Timeout, retry, fault
    phy_ready = 2'b00; pwr_good = 1'b0; edges(1); check("bo_idle", int'(seq_state), 0);
    pwr_good = 1'b1; edges(1); check("to_hold@0", int'(seq_state), 1);
    edges(13); check("to_retry@13", int'(seq_state), 1); check("to_phy@13", int'(phy_rst_l), 0);
    edges(12); check("to_wait@25", int'(seq_state), 3);
    edges(1); check("to_fault@26", int'(seq_state), 5); check("to_sfault@26", int'(seq_fault), 1);
    edges(3); check("fault_hold", int'(seq_fault), 1); check("fault_phy", int'(phy_rst_l), 0);

    // FAULT cleared by rst_req, retry count restored
    rst_req = 1'b1; edges(1); rst_req = 1'b0;
    check("clr_state", int'(seq_state), 1); check("clr_fault", int'(seq_fault), 0);
    edges(13); check("clr_retry_again", int'(seq_state), 1);
    edges(13); check("clr_fault2", int'(seq_state), 5);
    rst_req = 1'b1; pwr_good = 1'b0; edges(1); rst_req = 1'b0;
    check("pg_wins", int'(seq_state), 0); check("pg_wins_fault", int'(seq_fault), 0);

    // Brown-out during STAGGER
    pwr_good = 1'b1; edges(1); check("bo_hold@0", int'(seq_state), 1);
    edges(4); check("bo_stag@4", int'(seq_state), 2);
    pwr_good = 1'b0; edges(1);
    check("bo_idle@5", int'(seq_state), 0); check("bo_phy@5", int'(phy_rst_l), 0);
    pwr_good = 1'b1; edges(1); check("bo_restart", int'(seq_state), 1);
    edges(4); check("bo_rel0", int'(phy_rst_l), 1);

    // Async reset mid-WAIT_RDY
    edges(3); check("ar_wait", int'(seq_state), 3);
    #2 rst_l = 1'b0;
    #1 check("ar_phy", int'(phy_rst_l), 0); check("ar_state", int'(seq_state), 0);
    #3 rst_l = 1'b1;
    edges(1); check("ar_hold", int'(seq_state), 1);

    // Randomized traffic against the model
    begin
      int rmode = 0;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        if (c % 150 == 0) rmode = $urandom_range(0, 2);
        pwr_good  = ($urandom_range(0, 99) != 0);
        rst_req   = ($urandom_range(0, 59) == 0);
        phy_ready = (rmode == 0) ? 2'b11 : (rmode == 1) ? NP'($urandom) : 2'b00;
        if ($urandom_range(0, 999) == 0) begin
          #2 rst_l = 1'b0;
          #2 rst_l = 1'b1;
        end
      end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
